// File: rtl/mask_pkg.sv
// Shared types and constants for the multi-channel mask PRNG.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mask_pkg;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } prng_state_e;

    localparam logic [31:0] MASK_SALT_GOLDEN = 32'h9E37_79B9;
    localparam logic [31:0] SM4_MASK_POLY32  = 32'h0040_0006;

    // Per-channel salt before truncation/extension to the LFSR width.
    function automatic logic [31:0] mask_salt(input int unsigned k);
        return k * MASK_SALT_GOLDEN;
    endfunction

endpackage

// File: rtl/lfsr_galois_step.sv
// One combinational Galois LFSR step: rotate right, fold POLY in when the
// outgoing bit was set.
// Latency: combinational. Backpressure: none.
// Ports: state_i current state, state_o state after one step.
module lfsr_galois_step #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h0040_0006)
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);

    assign state_o = {state_i[0], state_i[WIDTH-1:1]} ^ (state_i[0] ? POLY : '0);

endmodule

// File: rtl/mask_prng.sv
// Multi-channel salted Galois LFSR mask generator with warm-up after reset/load.
// Latency: mask_o is the state register; valid WARMUP cycles after reset/load.
// Backpressure: state holds while mask_valid_o & !mask_ready_i; load_i wins over a handshake.
// Ports: clk_i, reset_n_i (sync, active-low), load_i/seed_i reseed all channels,
//        mask_valid_o/mask_ready_i/mask_o handshake (ch k at [k*WIDTH +: WIDTH]),
//        busy_o high during warm-up.
module mask_prng
    import mask_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(SM4_MASK_POLY32),
    parameter int               NUM_CH     = 4,
    parameter int               STEPS      = 1,
    parameter int               WARMUP     = 32,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(32'h0000_0001)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      load_i,
    input  logic [WIDTH-1:0]          seed_i,
    output logic                      mask_valid_o,
    input  logic                      mask_ready_i,
    output logic [NUM_CH*WIDTH-1:0]   mask_o,
    output logic                      busy_o
);

    // Counter must be able to hold the value WARMUP itself.
    localparam int          CNT_W    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam prng_state_e START_ST = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    prng_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic reseed, advance;

    logic [NUM_CH-1:0][WIDTH-1:0] st_q;
    logic [NUM_CH-1:0][WIDTH-1:0] st_adv;
    logic [NUM_CH-1:0][WIDTH-1:0] st_seed;

    // Reset and load share the seeding path; only the seed source differs.
    logic [WIDTH-1:0] seed_src;
    assign seed_src = reset_n_i ? seed_i : RESET_SEED;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        localparam logic [WIDTH-1:0] SALT = WIDTH'(mask_salt(ch));

        logic [STEPS:0][WIDTH-1:0] chain;
        logic [WIDTH-1:0]          salted;

        assign chain[0] = st_q[ch];
        for (genvar s = 0; s < STEPS; s++) begin : g_step
            lfsr_galois_step #(
                .WIDTH (WIDTH),
                .POLY  (POLY)
            ) u_step (
                .state_i (chain[s]),
                .state_o (chain[s+1])
            );
        end

        // An all-zero state would lock the LFSR forever; substitute 1.
        assign st_adv[ch]  = (chain[STEPS] == '0) ? WIDTH'(1) : chain[STEPS];
        assign salted      = seed_src ^ SALT;
        assign st_seed[ch] = (salted == '0) ? WIDTH'(1) : salted;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reseed  = 1'b0;
        advance = 1'b0;
        if (load_i) begin
            // Load discards any same-cycle handshake.
            reseed  = 1'b1;
            cnt_d   = '0;
            state_d = START_ST;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    advance = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(WARMUP)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    advance = mask_ready_i;
                end
                default: begin
                    state_d = START_ST;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= START_ST;
            cnt_q   <= '0;
            st_q    <= st_seed;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (reseed) begin
                st_q <= st_seed;
            end else if (advance) begin
                st_q <= st_adv;
            end
        end
    end

    assign mask_valid_o = (state_q == ST_RUN);
    assign busy_o       = (state_q == ST_WARMUP);
    assign mask_o       = st_q;

endmodule

// File: tb/tb_mask_prng.sv
module tb_mask_prng;

    // Three configurations: A default, B no warm-up, C narrow multi-step.
    localparam int          PW  [3] = '{32, 32, 16};
    localparam logic [63:0] PP  [3] = '{64'h0040_0006, 64'h0040_0006, 64'hB400};
    localparam int          PN  [3] = '{4, 4, 3};
    localparam int          PS  [3] = '{1, 1, 3};
    localparam int          PWU [3] = '{32, 0, 4};
    localparam logic [63:0] PRS [3] = '{64'h1, 64'h1, 64'h1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        ld    [3];
    logic        rdy   [3];
    logic [31:0] seed  [3];

    logic [127:0] mask_a, mask_b;
    logic [47:0]  mask_c;
    logic         vld_a, vld_b, vld_c, busy_a, busy_b, busy_c;

    logic [127:0] dmask [3];
    logic         dvld  [3];
    logic         dbusy [3];

    assign dmask[0] = mask_a;
    assign dmask[1] = mask_b;
    assign dmask[2] = {80'd0, mask_c};
    assign dvld[0]  = vld_a;
    assign dvld[1]  = vld_b;
    assign dvld[2]  = vld_c;
    assign dbusy[0] = busy_a;
    assign dbusy[1] = busy_b;
    assign dbusy[2] = busy_c;

    mask_prng u_a (
        .clk_i(clk), .reset_n_i(rst_n[0]), .load_i(ld[0]), .seed_i(seed[0]),
        .mask_valid_o(vld_a), .mask_ready_i(rdy[0]), .mask_o(mask_a), .busy_o(busy_a)
    );

    mask_prng #(.WARMUP(0)) u_b (
        .clk_i(clk), .reset_n_i(rst_n[1]), .load_i(ld[1]), .seed_i(seed[1]),
        .mask_valid_o(vld_b), .mask_ready_i(rdy[1]), .mask_o(mask_b), .busy_o(busy_b)
    );

    mask_prng #(.WIDTH(16), .POLY(16'hB400), .NUM_CH(3), .STEPS(3), .WARMUP(4),
                .RESET_SEED(16'h0001)) u_c (
        .clk_i(clk), .reset_n_i(rst_n[2]), .load_i(ld[2]), .seed_i(seed[2][15:0]),
        .mask_valid_o(vld_c), .mask_ready_i(rdy[2]), .mask_o(mask_c), .busy_o(busy_c)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] wmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] m_step(input logic [63:0] s, input int w, input logic [63:0] poly);
        logic [63:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r | (64'd1 << (w - 1));
            r = r ^ poly;
        end
        return r & wmask(w);
    endfunction

    function automatic logic [63:0] m_adv(input int i, input logic [63:0] s);
        logic [63:0] r;
        r = s;
        for (int n = 0; n < PS[i]; n++) r = m_step(r, PW[i], PP[i]);
        if (r == 64'd0) r = 64'd1;
        return r;
    endfunction

    function automatic logic [63:0] m_seed(input logic [63:0] sd, input int k, input int w);
        logic [31:0] salt32;
        logic [63:0] r;
        salt32 = k * 32'h9E37_79B9;
        r = (sd ^ {32'd0, salt32}) & wmask(w);
        if (r == 64'd0) r = 64'd1;
        return r;
    endfunction

    logic [63:0] m_st   [3][4];
    int          m_warm [3];
    bit          m_init [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i]) begin
                for (int k = 0; k < PN[i]; k++) m_st[i][k] = m_seed(PRS[i], k, PW[i]);
                m_warm[i] = PWU[i];
                m_init[i] = 1'b1;
            end else if (m_init[i]) begin
                if (ld[i]) begin
                    for (int k = 0; k < PN[i]; k++) m_st[i][k] = m_seed({32'd0, seed[i]}, k, PW[i]);
                    m_warm[i] = PWU[i];
                end else if (m_warm[i] > 0) begin
                    for (int k = 0; k < PN[i]; k++) m_st[i][k] = m_adv(i, m_st[i][k]);
                    m_warm[i]--;
                end else if (rdy[i]) begin
                    for (int k = 0; k < PN[i]; k++) m_st[i][k] = m_adv(i, m_st[i][k]);
                end
            end
        end
    end

    function automatic logic [63:0] dchan(input int i, input int k);
        return 64'(dmask[i] >> (k * PW[i])) & wmask(PW[i]);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (m_init[i]) begin
                chk($sformatf("dut%0d valid", i), {63'd0, dvld[i]}, {63'd0, m_warm[i] == 0});
                chk($sformatf("dut%0d busy", i), {63'd0, dbusy[i]}, {63'd0, m_warm[i] > 0});
                for (int k = 0; k < PN[i]; k++)
                    chk($sformatf("dut%0d ch%0d", i, k), dchan(i, k), m_st[i][k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_run(input int i, input int cycles, input int ld_odds);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rdy[i]  = 1'($urandom_range(0, 1));
            seed[i] = $urandom;
            ld[i]   = ($urandom_range(0, ld_odds) == 0);
        end
        @(negedge clk);
        ld[i]  = 1'b0;
        rdy[i] = 1'b0;
    endtask

    task automatic count_warm(input int i, input int expect_cycles, input string nm);
        int cnt;
        cnt = 0;
        while (!dvld[i] && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk(nm, 64'(cnt), 64'(expect_cycles));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; ld[i] = 1'b0; rdy[i] = 1'b0; seed[i] = '0;
        end
        repeat (3) @(negedge clk);

        // Reset values pinned by hand.
        chk("A rst valid", {63'd0, vld_a}, 64'd0);
        chk("A rst busy", {63'd0, busy_a}, 64'd1);
        chk("A rst ch0", 64'(mask_a[31:0]), 64'h0000_0001);
        chk("A rst ch1", 64'(mask_a[63:32]), 64'h9E37_79B8);
        chk("B rst valid", {63'd0, vld_b}, 64'd1);
        chk("B rst busy", {63'd0, busy_b}, 64'd0);
        chk("C rst ch1", 64'(mask_c[31:16]), 64'h79B8);
        chk("C rst ch2", 64'(mask_c[47:32]), 64'hF373);

        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        count_warm(0, 32, "A warmup after reset");

        // B: load seed 1, then two handshakes.
        ld[1] = 1'b1; seed[1] = 32'h1;
        @(negedge clk);
        ld[1] = 1'b0;
        chk("B load ch0", 64'(mask_b[31:0]), 64'h0000_0001);
        rdy[1] = 1'b1;
        @(negedge clk);
        chk("B adv1 ch0", 64'(mask_b[31:0]), 64'h8040_0006);
        @(negedge clk);
        chk("B adv2 ch0", 64'(mask_b[31:0]), 64'h4020_0003);
        rdy[1] = 1'b0;

        // A: stall 10 cycles, then 5 handshakes.
        repeat (10) @(negedge clk);
        rdy[0] = 1'b1;
        repeat (5) @(negedge clk);

        // A: load together with handshake, reload mid-warm-up.
        ld[0] = 1'b1; seed[0] = 32'h9E37_79B9;
        @(negedge clk);
        ld[0] = 1'b0; rdy[0] = 1'b0;
        chk("A salt ch0", 64'(mask_a[31:0]), 64'h9E37_79B9);
        chk("A salt ch1 guard", 64'(mask_a[63:32]), 64'h0000_0001);
        chk("A load busy", {63'd0, busy_a}, 64'd1);
        repeat (10) @(negedge clk);
        ld[0] = 1'b1; seed[0] = 32'h1234_5678;
        @(negedge clk);
        ld[0] = 1'b0;
        count_warm(0, 32, "A warmup after reload");

        // Random traffic on every configuration.
        rand_run(0, 300, 40);
        rand_run(1, 200, 15);
        rand_run(2, 300, 20);
        repeat (8) @(negedge clk);

        // C: mid-run reset, also overriding a load.
        rdy[2] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n[2] = 1'b0; ld[2] = 1'b1; seed[2] = 32'hFFFF;
        @(negedge clk);
        rst_n[2] = 1'b1; ld[2] = 1'b0; rdy[2] = 1'b0;
        chk("C rst mid ch0", 64'(mask_c[15:0]), 64'h0001);
        chk("C rst mid ch1", 64'(mask_c[31:16]), 64'h79B8);
        chk("C rst mid valid", {63'd0, vld_c}, 64'd0);
        count_warm(2, 4, "C warmup after reset");

        // A: mid-run reset while in RUN.
        rdy[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1; rdy[0] = 1'b0;
        chk("A rst mid ch0", 64'(mask_a[31:0]), 64'h0000_0001);
        chk("A rst mid valid", {63'd0, vld_a}, 64'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
